// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter sharing one synchronous-read RAM port; 3 cycles per access.
// Optional build macro ARB_ROUND_ROBIN_EN: unlocked ties alternate instead of favouring the CPU.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_rw,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_rw,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ack,
    input  logic                  dma_lock,
    output logic                  owner_dma,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    logic [1:0]       state;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_prev;   // previous grant was DMA with dma_lock high
    logic             is_read;
    logic             lock_active;
    logic             grant_cpu;
    logic             grant_dma;

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_dma;
`endif

    // A still-held request in the ack cycle is a new access; acks only come from WAIT,
    // so a port can never see two acks in one cycle.
    always_comb begin
        lock_active = lock_prev && (lock_cnt < LOCK_MAX);
        grant_cpu   = 1'b0;
        grant_dma   = 1'b0;
        if (state == IDLE) begin
            if (cpu_req && dma_req) begin
                if (lock_active) begin
                    grant_dma = 1'b1;
                end else begin
`ifdef ARB_ROUND_ROBIN_EN
                    grant_cpu = last_dma;
                    grant_dma = ~last_dma;
`else
                    grant_cpu = 1'b1;
`endif
                end
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (dma_req) begin
                grant_dma = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            lock_prev <= 1'b0;
            is_read   <= 1'b0;
            owner_dma <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma  <= 1'b1;
`endif
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu || grant_dma) begin
                        mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
                        mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
                        mem_we    <= grant_dma ? ~dma_rw   : ~cpu_rw;
                        is_read   <= grant_dma ? dma_rw    : cpu_rw;
                        owner_dma <= grant_dma;
                        state     <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_dma  <= grant_dma;
`endif
                        if (grant_dma && dma_lock) begin
                            lock_prev <= 1'b1;
                            if (lock_cnt < LOCK_MAX) begin
                                lock_cnt <= lock_cnt + CNT_W'(1);
                            end
                        end else begin
                            lock_prev <= 1'b0;
                            lock_cnt  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (owner_dma) begin
                        dma_ack <= 1'b1;
                        if (is_read) begin
                            dma_rdata <= mem_rdata;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (is_read) begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                    owner_dma <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
